// File: rtl/axis_s_interface.sv
// Receive-side AXI-Stream adapter: pops bytes from the RX CDC FIFO and packs them little-endian.
// Optional partial-word flush with m_axis_tkeep is enabled by defining AXIS_S_PARTIAL_FLUSH_EN.
module axis_s_interface #(
    parameter int unsigned LOGIC_SIZE    = 32,
    parameter int unsigned FLUSH_TIMEOUT = 16
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_reset_n,
    input  logic [7:0]              i_from_fifo,
    input  logic                    r_empty,
    output logic                    r_req,
    output logic [LOGIC_SIZE-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
`ifdef AXIS_S_PARTIAL_FLUSH_EN
    ,
    output logic [LOGIC_SIZE/8-1:0] m_axis_tkeep
`endif
);

    localparam int unsigned NB = LOGIC_SIZE / 8;
    localparam int unsigned CW = $clog2(NB);

    if ((LOGIC_SIZE % 8) != 0 || LOGIC_SIZE < 16) begin : g_bad_size
        $error("axis_s_interface: LOGIC_SIZE must be a multiple of 8 and at least 16");
    end
    if (FLUSH_TIMEOUT < 2) begin : g_bad_timeout
        $error("axis_s_interface: FLUSH_TIMEOUT must be at least 2");
    end

    logic                    r_rd_vld;
    logic [CW-1:0]           r_cnt;
    logic [NB-2:0][7:0]      r_asm;
    logic [LOGIC_SIZE-1:0]   r_tdata;
    logic                    r_tvalid;

    logic                    w_last;
    logic                    w_complete;
    logic                    w_handshake;
    logic                    w_stall;
    logic [CW:0]             w_next_lane;
    logic [LOGIC_SIZE-1:0]   w_word;

    assign w_last      = (r_cnt == CW'(NB - 1));
    assign w_complete  = r_rd_vld && w_last;
    assign w_handshake = r_tvalid && m_axis_tready;
    assign w_word      = {i_from_fifo, r_asm};

    // Lane the byte requested now would land in; withholding the final lane while the output is
    // blocked guarantees a completed word always finds the output register free.
    assign w_next_lane = {1'b0, r_cnt} + (CW + 1)'(r_rd_vld);
    assign w_stall     = r_tvalid && !m_axis_tready && (w_next_lane == (CW + 1)'(NB - 1));

    assign r_req = !r_empty && !w_stall && m_axis_reset_n;

`ifdef AXIS_S_PARTIAL_FLUSH_EN
    localparam int unsigned IW = $clog2(FLUSH_TIMEOUT + 1);

    logic [IW-1:0]           r_idle;
    logic [NB-1:0]           r_tkeep;
    logic                    w_idle;
    logic                    w_flush;
    logic [LOGIC_SIZE-1:0]   w_flush_data;
    logic [NB-1:0]           w_flush_keep;

    assign w_idle  = (r_cnt != '0) && !r_rd_vld && r_empty;
    assign w_flush = w_idle && (r_idle == IW'(FLUSH_TIMEOUT)) && !r_tvalid;

    // Stale lanes from earlier words are masked so unused lanes read as zero.
    always_comb begin
        w_flush_data = '0;
        w_flush_keep = '0;
        for (int l = 0; l < NB - 1; l++) begin
            if (CW'(l) < r_cnt) begin
                w_flush_data[8*l +: 8] = r_asm[l];
                w_flush_keep[l]        = 1'b1;
            end
        end
    end

    // Saturates at the timeout so a flush blocked by a pending beat fires once it drains.
    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            r_idle <= '0;
        end else if (!w_idle || w_flush) begin
            r_idle <= '0;
        end else if (r_idle != IW'(FLUSH_TIMEOUT)) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign m_axis_tkeep = r_tkeep;
`endif

    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            r_rd_vld <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_rd_vld <= r_req;
            if (r_rd_vld) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
`ifdef AXIS_S_PARTIAL_FLUSH_EN
            else if (w_flush) begin
                r_cnt <= '0;
            end
`endif
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            r_asm <= '0;
        end else begin
            for (int l = 0; l < NB - 1; l++) begin
                if (r_rd_vld && (r_cnt == CW'(l))) begin
                    r_asm[l] <= i_from_fifo;
                end
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
        if (!m_axis_reset_n) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
`ifdef AXIS_S_PARTIAL_FLUSH_EN
            r_tkeep  <= '0;
`endif
        end else if (w_complete) begin
            r_tdata  <= w_word;
            r_tvalid <= 1'b1;
`ifdef AXIS_S_PARTIAL_FLUSH_EN
            r_tkeep  <= '1;
        end else if (w_flush) begin
            r_tdata  <= w_flush_data;
            r_tvalid <= 1'b1;
            r_tkeep  <= w_flush_keep;
`endif
        end else if (w_handshake) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;

    a_no_overwrite: assert property (@(posedge m_axis_aclk) disable iff (!m_axis_reset_n)
        w_complete |-> !(r_tvalid && !m_axis_tready));

    a_hold_stable: assert property (@(posedge m_axis_aclk) disable iff (!m_axis_reset_n)
        (r_tvalid && !m_axis_tready) |=> (r_tvalid && $stable(r_tdata)));

endmodule

// File: tb/tb_axis_s_interface.sv
// Directed self-checking bench for axis_s_interface with a 1-cycle-latency FIFO model.
module tb_axis_s_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_from_fifo = 8'h00;
    logic        r_empty;
    logic        r_req;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
`ifdef AXIS_S_PARTIAL_FLUSH_EN
    logic [3:0]  tkeep;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0]  mem [0:511];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          req_n = 0;
    int          req_cyc [0:511];
    int          beat_n = 0;
    logic [31:0] beat_data [0:63];
    logic [3:0]  beat_keep [0:63];
    int          beat_cyc [0:63];

    axis_s_interface #(
        .LOGIC_SIZE    (32),
        .FLUSH_TIMEOUT (16)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_reset_n (rst_n),
        .i_from_fifo    (i_from_fifo),
        .r_empty        (r_empty),
        .r_req          (r_req),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready)
`ifdef AXIS_S_PARTIAL_FLUSH_EN
        ,
        .m_axis_tkeep   (tkeep)
`endif
    );

    always #5 clk = ~clk;

    assign r_empty = (wr_ptr == rd_ptr);

    // FIFO read model plus request / beat logging.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r_req) begin
            i_from_fifo       <= mem[rd_ptr[8:0]];
            rd_ptr            <= rd_ptr + 1;
            req_cyc[req_n[8:0]] <= cyc;
            req_n             <= req_n + 1;
        end
        if (tvalid && tready) begin
            beat_data[beat_n[5:0]] <= tdata;
            beat_cyc[beat_n[5:0]]  <= cyc;
`ifdef AXIS_S_PARTIAL_FLUSH_EN
            beat_keep[beat_n[5:0]] <= tkeep;
`else
            beat_keep[beat_n[5:0]] <= 4'hF;
`endif
            beat_n <= beat_n + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[8:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input int target, input int bound);
        for (int i = 0; i < bound && beat_n < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push(8'h01);
        push(8'h02);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (r_req !== 1'b0) begin
                fails++; $display("FAIL reset_r_req: got %b expected 0", r_req);
            end
            tests++;
            if (tvalid !== 1'b0) begin
                fails++; $display("FAIL reset_tvalid: got %b expected 0", tvalid);
            end
            tests++;
            if (tdata !== 32'h0) begin
                fails++; $display("FAIL reset_tdata: got %h expected 00000000", tdata);
            end
        end
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int rb;
        int bb;
        tready = 1'b1;
        rb = req_n;
        bb = beat_n;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_beats(bb + 1, 20);
        repeat (3) @(negedge clk);
        tests++;
        if (beat_n - bb !== 1) begin
            fails++; $display("FAIL single_beats: got %0d expected 1", beat_n - bb);
        end
        tests++;
        if (beat_data[bb] !== 32'h44332211) begin
            fails++; $display("FAIL single_tdata: got %h expected 44332211", beat_data[bb]);
        end
        tests++;
        if (beat_cyc[bb] - req_cyc[rb + 3] !== 2) begin
            fails++;
            $display("FAIL single_latency: got %0d expected 2", beat_cyc[bb] - req_cyc[rb + 3]);
        end
        tests++;
        if (tvalid !== 1'b0) begin
            fails++; $display("FAIL single_tvalid_drop: got %b expected 0", tvalid);
        end
`ifdef AXIS_S_PARTIAL_FLUSH_EN
        tests++;
        if (beat_keep[bb] !== 4'hF) begin
            fails++; $display("FAIL single_tkeep: got %h expected f", beat_keep[bb]);
        end
`endif
    endtask

    task automatic test_backpressure();
        int rb;
        int bb;
        logic [31:0] exp;
        tready = 1'b0;
        rb = req_n;
        bb = beat_n;
        for (int i = 0; i < 12; i++) push(8'(i));
        repeat (20) @(negedge clk);
        tests++;
        if (req_n - rb !== 7) begin
            fails++; $display("FAIL bp_reads: got %0d expected 7", req_n - rb);
        end
        tests++;
        if (r_req !== 1'b0) begin
            fails++; $display("FAIL bp_r_req: got %b expected 0", r_req);
        end
        tests++;
        if (tvalid !== 1'b1 || tdata !== 32'h03020100) begin
            fails++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=03020100", tvalid, tdata);
        end
        tready = 1'b1;
        wait_beats(bb + 3, 30);
        repeat (3) @(negedge clk);
        tests++;
        if (beat_n - bb !== 3 || req_n - rb !== 12) begin
            fails++;
            $display("FAIL bp_counts: got beats=%0d reads=%0d expected beats=3 reads=12",
                     beat_n - bb, req_n - rb);
        end
        for (int k = 0; k < 3; k++) begin
            exp = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
            tests++;
            if (beat_data[bb + k] !== exp) begin
                fails++; $display("FAIL bp_beat%0d: got %h expected %h", k, beat_data[bb + k], exp);
            end
        end
    endtask

    task automatic test_stream();
        int rb;
        int bb;
        logic [31:0] exp;
        tready = 1'b1;
        rb = req_n;
        bb = beat_n;
        for (int i = 0; i < 64; i++) push(8'(i * 5 + 7));
        wait_beats(bb + 16, 100);
        repeat (3) @(negedge clk);
        tests++;
        if (req_n - rb !== 64) begin
            fails++; $display("FAIL stream_reads: got %0d expected 64", req_n - rb);
        end
        tests++;
        if (req_cyc[rb + 63] - req_cyc[rb] !== 63) begin
            fails++;
            $display("FAIL stream_req_span: got %0d expected 63", req_cyc[rb + 63] - req_cyc[rb]);
        end
        tests++;
        if (beat_n - bb !== 16) begin
            fails++; $display("FAIL stream_beats: got %0d expected 16", beat_n - bb);
        end
        for (int k = 0; k < 16; k++) begin
            exp = {8'((4*k + 3) * 5 + 7), 8'((4*k + 2) * 5 + 7),
                   8'((4*k + 1) * 5 + 7), 8'((4*k) * 5 + 7)};
            tests++;
            if (beat_data[bb + k] !== exp) begin
                fails++;
                $display("FAIL stream_beat%0d: got %h expected %h", k, beat_data[bb + k], exp);
            end
            if (k > 0) begin
                tests++;
                if (beat_cyc[bb + k] - beat_cyc[bb + k - 1] !== 4) begin
                    fails++;
                    $display("FAIL stream_gap%0d: got %0d expected 4", k,
                             beat_cyc[bb + k] - beat_cyc[bb + k - 1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rb;
        int bb;
        tready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        for (int i = 0; i < 20 && tvalid !== 1'b1; i++) @(negedge clk);
        rb = req_n;
        push(8'h55); push(8'h66);
        for (int i = 0; i < 10 && req_n < rb + 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (tvalid !== 1'b0 || tdata !== 32'h0) begin
            fails++; $display("FAIL midrst_clear: got v=%b d=%h expected v=0 d=00000000", tvalid, tdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        bb = beat_n;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        wait_beats(bb + 1, 20);
        repeat (6) @(negedge clk);
        tests++;
        if (beat_n - bb !== 1) begin
            fails++; $display("FAIL midrst_beats: got %0d expected 1", beat_n - bb);
        end
        tests++;
        if (beat_data[bb] !== 32'hA4A3A2A1) begin
            fails++; $display("FAIL midrst_tdata: got %h expected a4a3a2a1", beat_data[bb]);
        end
    endtask

`ifdef AXIS_S_PARTIAL_FLUSH_EN
    task automatic test_flush();
        int rb;
        int bb;
        tready = 1'b1;
        rb = req_n;
        bb = beat_n;
        push(8'hAA); push(8'hBB); push(8'hCC);
        for (int i = 0; i < 10 && req_n < rb + 3; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        tests++;
        if (tvalid !== 1'b0) begin
            fails++; $display("FAIL flush_early: got %b expected 0", tvalid);
        end
        wait_beats(bb + 1, 30);
        tests++;
        if (beat_n - bb !== 1 || beat_data[bb] !== 32'h00CCBBAA) begin
            fails++;
            $display("FAIL flush_tdata: got n=%0d d=%h expected n=1 d=00ccbbaa",
                     beat_n - bb, beat_data[bb]);
        end
        tests++;
        if (beat_keep[bb] !== 4'b0111) begin
            fails++; $display("FAIL flush_tkeep: got %b expected 0111", beat_keep[bb]);
        end
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_beats(bb + 2, 20);
        tests++;
        if (beat_data[bb + 1] !== 32'h04030201 || beat_keep[bb + 1] !== 4'hF) begin
            fails++;
            $display("FAIL flush_after: got d=%h k=%h expected d=04030201 k=f",
                     beat_data[bb + 1], beat_keep[bb + 1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_reset_mid();
`ifdef AXIS_S_PARTIAL_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
